fp_cond_branch_unit: RTL and testbench

Consumer side of the double-precision FP compare: accepts the single-bit compare result produced in EX, carries it down the EX→MEM→WB pipe, commits it to the architectural FP condition flag (FCC), and resolves bc1t/bc1f branches in ID. Forwards in-flight results, stalls ID when the result is not yet forwardable, and produces branch taken/target for the fetch stage.

---
 rtl/fcc_pkg.sv | 18 +
 rtl/fcc_forward_pipe.sv | 48 ++++
 rtl/fp_cond_branch_unit.sv | 78 +++++++
 tb/tb_fp_cond_branch_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fcc_pkg.sv
// Shared types and defaults for the FP condition-flag / bc1t/bc1f branch unit.
package fcc_pkg;
    localparam int PC_W_DEF  = 32;
    localparam int OFF_W_DEF = 16;

    // RESOLVE: normal zero-cycle branch resolution; WAIT_EX: compare moved EX->MEM, resolve from MEM
    typedef enum logic {
        RESOLVE = 1'b0,
        WAIT_EX = 1'b1
    } state_t;

    // Source of the effective flag; the youngest in-flight result wins
    typedef enum logic [1:0] {
        FWD_MEM  = 2'd0,
        FWD_WB   = 2'd1,
        FWD_ARCH = 2'd2
    } fwd_sel_t;
endpackage

// File: rtl/fcc_forward_pipe.sv
// MEM/WB carry of the FP compare result, FCC commit and effective-flag forwarding mux.
module fcc_forward_pipe
    import fcc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_adv,       // pipe advances this cycle (no global freeze)
    input  logic i_cmp_v,     // compare leaving EX, already flush-qualified
    input  logic i_cmp_r,
    output logic o_mem_r,
    output logic o_fcc,
    output logic o_eff_flag
);
    logic     r_mem_v, r_mem_r, r_wb_v, r_wb_r, r_fcc;
    fwd_sel_t w_sel;

    // Shift the compare down EX->MEM->WB and commit to FCC out of WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_v <= 1'b0;
            r_mem_r <= 1'b0;
            r_wb_v  <= 1'b0;
            r_wb_r  <= 1'b0;
            r_fcc   <= 1'b0;
        end else if (i_adv) begin
            r_mem_v <= i_cmp_v;
            r_mem_r <= i_cmp_r;
            r_wb_v  <= r_mem_v;
            r_wb_r  <= r_mem_r;
            if (r_wb_v) r_fcc <= r_wb_r;
        end
    end

    // Pick the youngest valid result: MEM, then WB, then the architectural flag
    always_comb begin
        w_sel = FWD_ARCH;
        if (r_mem_v)     w_sel = FWD_MEM;
        else if (r_wb_v) w_sel = FWD_WB;
        case (w_sel)
            FWD_MEM: o_eff_flag = r_mem_r;
            FWD_WB:  o_eff_flag = r_wb_r;
            default: o_eff_flag = r_fcc;
        endcase
    end

    assign o_mem_r = r_mem_r;
    assign o_fcc   = r_fcc;
endmodule

// File: rtl/fp_cond_branch_unit.sv
// bc1t/bc1f resolution in ID against the forwarded FP condition flag, with a
// one-cycle stall when the producing compare is still in EX.
module fp_cond_branch_unit
    import fcc_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int OFF_W = OFF_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmp_valid_ex,
    input  logic             cmp_result_ex,
    input  logic             flush,
    input  logic             stall_ext,
    input  logic             br_valid_id,
    input  logic             br_tf_id,
    input  logic [PC_W-1:0]  br_pc_id,
    input  logic [OFF_W-1:0] br_offset_id,
    output logic             fcc_o,
    output logic             br_stall_o,
    output logic             br_taken_o,
    output logic [PC_W-1:0]  br_target_o
);
    state_t          r_state, w_state_nxt;
    logic            w_mem_r, w_eff_flag, w_flag, w_stall, w_taken;
    logic [PC_W-1:0] w_off_ext;

    // EX result is late-arriving and never forwarded; only MEM/WB/FCC feed the mux
    fcc_forward_pipe u_pipe (
        .clk        (clk),
        .rst        (rst),
        .i_adv      (~stall_ext),
        .i_cmp_v    (cmp_valid_ex & ~flush),
        .i_cmp_r    (cmp_result_ex),
        .o_mem_r    (w_mem_r),
        .o_fcc      (fcc_o),
        .o_eff_flag (w_eff_flag)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RESOLVE;
        else     r_state <= w_state_nxt;
    end

    // Next state, stall and taken decision; reset forces outputs quiet immediately
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_flag      = w_eff_flag;
        case (r_state)
            RESOLVE: begin
                if (br_valid_id && cmp_valid_ex) begin
                    w_stall     = 1'b1;
                    w_state_nxt = WAIT_EX;
                end
            end
            WAIT_EX: begin
                w_flag      = w_mem_r;
                w_state_nxt = RESOLVE;
            end
            default: w_state_nxt = RESOLVE;
        endcase
        if (stall_ext) w_state_nxt = r_state;
        if (flush) begin
            w_stall     = 1'b0;
            w_state_nxt = RESOLVE;
        end
        if (rst) w_stall = 1'b0;
        w_taken = br_valid_id & ~flush & ~rst & ~w_stall & (w_flag == br_tf_id);
    end

    assign br_stall_o  = w_stall;
    assign br_taken_o  = w_taken;
    // Word offset: sign-extend then scale by 4, wrapping modulo 2^PC_W
    assign w_off_ext   = {{(PC_W-OFF_W){br_offset_id[OFF_W-1]}}, br_offset_id};
    assign br_target_o = br_pc_id + {w_off_ext[PC_W-3:0], 2'b00};
endmodule

// File: tb/tb_fp_cond_branch_unit.sv
// Directed bench for fp_cond_branch_unit: forwarding, stall, flush, freeze, reset.
module tb_fp_cond_branch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmp_valid_ex, cmp_result_ex, flush, stall_ext;
    logic        br_valid_id, br_tf_id;
    logic [31:0] br_pc_id;
    logic [15:0] br_offset_id;
    logic        fcc_o, br_stall_o, br_taken_o;
    logic [31:0] br_target_o;
    int          tests = 0;
    int          fails = 0;

    fp_cond_branch_unit dut (
        .clk(clk), .rst(rst), .cmp_valid_ex(cmp_valid_ex), .cmp_result_ex(cmp_result_ex),
        .flush(flush), .stall_ext(stall_ext), .br_valid_id(br_valid_id), .br_tf_id(br_tf_id),
        .br_pc_id(br_pc_id), .br_offset_id(br_offset_id), .fcc_o(fcc_o),
        .br_stall_o(br_stall_o), .br_taken_o(br_taken_o), .br_target_o(br_target_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        cmp_valid_ex = 0; cmp_result_ex = 0; flush = 0; stall_ext = 0;
        br_valid_id = 0; br_tf_id = 0; br_pc_id = '0; br_offset_id = '0;
    endtask

    task automatic test_reset;
        clr(); rst = 1;
        br_valid_id = 1; br_tf_id = 0;
        #2;
        tests++; if (fcc_o !== 1'b0) begin fails++; $display("FAIL reset_fcc got %b exp 0", fcc_o); end
        tests++; if (br_stall_o !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", br_stall_o); end
        tests++; if (br_taken_o !== 1'b0) begin fails++; $display("FAIL reset_taken got %b exp 0", br_taken_o); end
        tick(); tick();
        rst = 0; clr();
        tick();
    endtask

    // compare=1 and bc1t together: one stall, then taken; FCC visible 3 cycles later
    task automatic test_stall_branch;
        cmp_valid_ex = 1; cmp_result_ex = 1; br_valid_id = 1; br_tf_id = 1;
        #1;
        tests++; if (br_stall_o !== 1'b1) begin fails++; $display("FAIL stallN got %b exp 1", br_stall_o); end
        tests++; if (br_taken_o !== 1'b0) begin fails++; $display("FAIL stallN_taken got %b exp 0", br_taken_o); end
        tick();
        cmp_valid_ex = 0; cmp_result_ex = 0;
        #1;
        tests++; if (br_stall_o !== 1'b0) begin fails++; $display("FAIL stallN1 got %b exp 0", br_stall_o); end
        tests++; if (br_taken_o !== 1'b1) begin fails++; $display("FAIL takenN1 got %b exp 1", br_taken_o); end
        tick();
        br_valid_id = 0;
        #1;
        tests++; if (fcc_o !== 1'b0) begin fails++; $display("FAIL fccN2 got %b exp 0", fcc_o); end
        tick();
        tests++; if (fcc_o !== 1'b1) begin fails++; $display("FAIL fccN3 got %b exp 1", fcc_o); end
        clr();
    endtask

    // fcc=1 entering; compare 1 then compare 0: MEM(0) beats WB(1), then WB(0) beats FCC(1)
    task automatic test_back_to_back;
        cmp_valid_ex = 1; cmp_result_ex = 1; tick();
        cmp_valid_ex = 1; cmp_result_ex = 0; tick();
        cmp_valid_ex = 0; br_valid_id = 1; br_tf_id = 0;
        #1;
        tests++; if (br_stall_o !== 1'b0) begin fails++; $display("FAIL b2b_stall got %b exp 0", br_stall_o); end
        tests++; if (br_taken_o !== 1'b1) begin fails++; $display("FAIL b2b_mem_bc1f got %b exp 1", br_taken_o); end
        br_tf_id = 1;
        #1;
        tests++; if (br_taken_o !== 1'b0) begin fails++; $display("FAIL b2b_mem_bc1t got %b exp 0", br_taken_o); end
        tick();
        br_tf_id = 0;
        #1;
        tests++; if (br_taken_o !== 1'b1) begin fails++; $display("FAIL b2b_wb_bc1f got %b exp 1", br_taken_o); end
        tests++; if (fcc_o !== 1'b1) begin fails++; $display("FAIL b2b_fccN3 got %b exp 1", fcc_o); end
        tick();
        br_valid_id = 0;
        #1;
        tests++; if (fcc_o !== 1'b0) begin fails++; $display("FAIL b2b_fccN4 got %b exp 0", fcc_o); end
        clr();
    endtask

    task automatic test_target;
        cmp_valid_ex = 1; cmp_result_ex = 1; tick();
        clr(); tick(); tick();
        tests++; if (fcc_o !== 1'b1) begin fails++; $display("FAIL tgt_fcc got %b exp 1", fcc_o); end
        br_valid_id = 1; br_tf_id = 0; br_pc_id = 32'h100; br_offset_id = 16'hFFFF;
        #1;
        tests++; if (br_taken_o !== 1'b0) begin fails++; $display("FAIL tgt_bc1f_taken got %b exp 0", br_taken_o); end
        tests++; if (br_target_o !== 32'h0000_00FC) begin fails++; $display("FAIL tgt_neg got %h exp 000000fc", br_target_o); end
        br_tf_id = 1; br_pc_id = 32'h1000; br_offset_id = 16'h0010;
        #1;
        tests++; if (br_taken_o !== 1'b1) begin fails++; $display("FAIL tgt_bc1t_taken got %b exp 1", br_taken_o); end
        tests++; if (br_target_o !== 32'h0000_1040) begin fails++; $display("FAIL tgt_pos got %h exp 00001040", br_target_o); end
        br_pc_id = 32'hFFFF_FFFC; br_offset_id = 16'h0001;
        #1;
        tests++; if (br_target_o !== 32'h0000_0000) begin fails++; $display("FAIL tgt_wrap got %h exp 00000000", br_target_o); end
        br_pc_id = 32'h0; br_offset_id = 16'h7FFF;
        #1;
        tests++; if (br_target_o !== 32'h0001_FFFC) begin fails++; $display("FAIL tgt_maxpos got %h exp 0001fffc", br_target_o); end
        tick(); clr();
    endtask

    task automatic test_flush;
        cmp_valid_ex = 1; cmp_result_ex = 0; tick();
        clr(); tick(); tick();
        tests++; if (fcc_o !== 1'b0) begin fails++; $display("FAIL fl_pre_fcc got %b exp 0", fcc_o); end
        cmp_valid_ex = 1; cmp_result_ex = 1; flush = 1; br_valid_id = 1; br_tf_id = 1;
        #1;
        tests++; if (br_stall_o !== 1'b0) begin fails++; $display("FAIL fl_stall got %b exp 0", br_stall_o); end
        tests++; if (br_taken_o !== 1'b0) begin fails++; $display("FAIL fl_taken got %b exp 0", br_taken_o); end
        tick();
        clr(); br_valid_id = 1; br_tf_id = 1;
        #1;
        tests++; if (br_taken_o !== 1'b0) begin fails++; $display("FAIL fl_next_bc1t got %b exp 0", br_taken_o); end
        tick(); br_valid_id = 0; tick(); tick();
        tests++; if (fcc_o !== 1'b0) begin fails++; $display("FAIL fl_fcc got %b exp 0", fcc_o); end
        clr();
    endtask

    // fcc=0 entering; freeze 3 cycles with compare(1) in MEM
    task automatic test_stall_ext;
        cmp_valid_ex = 1; cmp_result_ex = 1; tick();
        clr(); stall_ext = 1; br_valid_id = 1; br_tf_id = 1;
        #1;
        tests++; if (br_taken_o !== 1'b1) begin fails++; $display("FAIL se_mem_fwd got %b exp 1", br_taken_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (fcc_o !== 1'b0 || br_taken_o !== 1'b1) begin
                fails++; $display("FAIL se_frozen%0d fcc %b taken %b exp 0 1", i, fcc_o, br_taken_o);
            end
        end
        stall_ext = 0; br_valid_id = 0;
        tick();
        tests++; if (fcc_o !== 1'b0) begin fails++; $display("FAIL se_rel1 got %b exp 0", fcc_o); end
        tick();
        tests++; if (fcc_o !== 1'b1) begin fails++; $display("FAIL se_rel2 got %b exp 1", fcc_o); end
        clr();
    endtask

    // fcc=1 entering; reset during a stall discards the in-flight compare
    task automatic test_rst_mid_stall;
        cmp_valid_ex = 1; cmp_result_ex = 1; br_valid_id = 1; br_tf_id = 1;
        #1;
        tests++; if (br_stall_o !== 1'b1) begin fails++; $display("FAIL rs_stall got %b exp 1", br_stall_o); end
        tick();
        rst = 1;
        #1;
        tests++; if (br_stall_o !== 1'b0) begin fails++; $display("FAIL rs_stall_rst got %b exp 0", br_stall_o); end
        tests++; if (br_taken_o !== 1'b0) begin fails++; $display("FAIL rs_taken_rst got %b exp 0", br_taken_o); end
        tests++; if (fcc_o !== 1'b0) begin fails++; $display("FAIL rs_fcc_rst got %b exp 0", fcc_o); end
        tick();
        rst = 0; cmp_valid_ex = 0;
        #1;
        tests++; if (br_taken_o !== 1'b0 || br_stall_o !== 1'b0) begin
            fails++; $display("FAIL rs_after taken %b stall %b exp 0 0", br_taken_o, br_stall_o);
        end
        tick(); clr(); tick();
        tests++; if (fcc_o !== 1'b0) begin fails++; $display("FAIL rs_discard got %b exp 0", fcc_o); end
    endtask

    initial begin
        test_reset();
        test_stall_branch();
        test_back_to_back();
        test_target();
        test_flush();
        test_stall_ext();
        test_rst_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
